bp_mem_link_concentrator: RTL and testbench

- Concentrates num_in_p memory-NoC ready-and channels onto one DRAM-facing link, so multicore configurations can have more memory channels than physical DRAM links.
- Forward (command) path: round-robin arbitration with wormhole locking per packet. The winning input's index is written into the header's cid field.
- Reverse (response) path: the cid field in each response header steers the whole response packet back to the matching channel.
- Sits between the multicore's memory links and the chip's DRAM link pins.

---
 rtl/bp_mem_link_concentrator_if.sv | 30 +++
 rtl/bp_mem_link_concentrator.sv | 205 ++++++++++++++++++++
 tb/tb_bp_mem_link_concentrator.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_mem_link_concentrator_if.sv
// Memory-link bundle between num_in_p NoC channels and one DRAM link.
// Slave is the concentrator's view; master is the surrounding system.
`timescale 1ns/1ps
interface bp_mem_link_concentrator_if #(
  parameter int num_in_p     = 4,
  parameter int flit_width_p = 64
);
  logic [num_in_p-1:0][flit_width_p-1:0] cmd_data_i;
  logic [num_in_p-1:0]                   cmd_v_i;
  logic [num_in_p-1:0]                   cmd_ready_and_o;
  logic [flit_width_p-1:0]               cmd_data_o;
  logic                                  cmd_v_o;
  logic                                  cmd_ready_and_i;
  logic [flit_width_p-1:0]               resp_data_i;
  logic                                  resp_v_i;
  logic                                  resp_ready_and_o;
  logic [num_in_p-1:0][flit_width_p-1:0] resp_data_o;
  logic [num_in_p-1:0]                   resp_v_o;
  logic [num_in_p-1:0]                   resp_ready_and_i;

  modport slave (
    input  cmd_data_i, cmd_v_i, cmd_ready_and_i, resp_data_i, resp_v_i, resp_ready_and_i,
    output cmd_ready_and_o, cmd_data_o, cmd_v_o, resp_ready_and_o, resp_data_o, resp_v_o
  );

  modport master (
    output cmd_data_i, cmd_v_i, cmd_ready_and_i, resp_data_i, resp_v_i, resp_ready_and_i,
    input  cmd_ready_and_o, cmd_data_o, cmd_v_o, resp_ready_and_o, resp_data_o, resp_v_o
  );
endinterface

// File: rtl/bp_mem_link_concentrator.sv
// Concentrates num_in_p memory channels onto one DRAM link: round-robin wormhole
// arbitration on commands, cid-steered packet routing on responses.
`timescale 1ns/1ps
module bp_mem_link_concentrator #(
  parameter int num_in_p     = 4,
  parameter int flit_width_p = 64,
  parameter int len_width_p  = 4,
  parameter int len_offset_p = 0,
  parameter int cid_width_p  = $clog2(num_in_p),
  parameter int cid_offset_p = 4
) (
  input logic clk_i,
  input logic reset_i,
  bp_mem_link_concentrator_if.slave link
);
  typedef enum logic {E_IDLE, E_BUSY} state_e;
  typedef logic [flit_width_p-1:0] flit_t;
  typedef logic [cid_width_p-1:0]  cid_t;
  typedef logic [len_width_p-1:0]  len_t;

  function automatic cid_t next_ch(cid_t p);
    return (int'(p) == num_in_p-1) ? '0 : cid_t'(p + 1'b1);
  endfunction

  // forward path state
  flit_t      f_mem_q [2];
  flit_t      f_mem_d [2];
  logic       f_wr_q, f_wr_d, f_rd_q, f_rd_d;
  logic [1:0] f_cnt_q, f_cnt_d;
  state_e     f_state_q, f_state_d;
  len_t       f_len_q, f_len_d;
  cid_t       rr_q, rr_d, lock_q, lock_d;

  // reverse path state
  flit_t      r_mem_q [2];
  flit_t      r_mem_d [2];
  logic       r_wr_q, r_wr_d, r_rd_q, r_rd_d;
  logic [1:0] r_cnt_q, r_cnt_d;
  state_e     r_state_q, r_state_d;
  len_t       r_len_q, r_len_d;
  cid_t       r_dest_q, r_dest_d;
  logic       r_drop_q, r_drop_d;

  cid_t                grant;
  logic                any_v, f_space, f_enq, f_deq;
  flit_t               f_in;
  logic [num_in_p-1:0] cmd_rdy, r_vo;
  logic                r_hv, r_enq, r_deq, resp_rdy;
  flit_t               r_head;
  cid_t                h_cid;
  len_t                h_len;

  // lowest offset from rr_q wins, so scan downward and let later hits override
  always_comb begin
    grant = rr_q;
    any_v = 1'b0;
    for (int i = num_in_p-1; i >= 0; i--) begin
      if (link.cmd_v_i[cid_t'((int'(rr_q) + i) % num_in_p)]) begin
        grant = cid_t'((int'(rr_q) + i) % num_in_p);
        any_v = 1'b1;
      end
    end
  end

  always_comb begin
    f_space   = (f_cnt_q != 2'd2) || link.cmd_ready_and_i;
    f_deq     = (f_cnt_q != 2'd0) && link.cmd_ready_and_i;
    cmd_rdy   = '0;
    f_enq     = 1'b0;
    f_in      = link.cmd_data_i[lock_q];
    f_state_d = f_state_q;
    f_len_d   = f_len_q;
    rr_d      = rr_q;
    lock_d    = lock_q;
    if (f_state_q == E_IDLE) begin
      f_in = link.cmd_data_i[grant];
      f_in[cid_offset_p +: cid_width_p] = grant;
      cmd_rdy[grant] = any_v & f_space;
      f_enq = any_v & f_space;
      if (f_enq) begin
        f_len_d = f_in[len_offset_p +: len_width_p];
        if (f_len_d == '0) rr_d = next_ch(grant);
        else begin
          f_state_d = E_BUSY;
          lock_d    = grant;
        end
      end
    end else begin
      cmd_rdy[lock_q] = f_space;
      f_enq = link.cmd_v_i[lock_q] & f_space;
      if (f_enq) begin
        f_len_d = f_len_q - 1'b1;
        if (f_len_q == len_t'(1)) begin
          f_state_d = E_IDLE;
          rr_d      = next_ch(lock_q);
        end
      end
    end
    f_mem_d = f_mem_q;
    f_wr_d  = f_wr_q;
    f_rd_d  = f_rd_q;
    if (f_enq) begin
      f_mem_d[f_wr_q] = f_in;
      f_wr_d = ~f_wr_q;
    end
    if (f_deq) f_rd_d = ~f_rd_q;
    f_cnt_d = f_cnt_q + {1'b0, f_enq} - {1'b0, f_deq};
  end

  always_comb begin
    resp_rdy  = (r_cnt_q != 2'd2) && !reset_i;
    r_enq     = link.resp_v_i && resp_rdy;
    r_head    = r_mem_q[r_rd_q];
    r_hv      = (r_cnt_q != 2'd0);
    h_cid     = r_head[cid_offset_p +: cid_width_p];
    h_len     = r_head[len_offset_p +: len_width_p];
    r_vo      = '0;
    r_deq     = 1'b0;
    r_state_d = r_state_q;
    r_len_d   = r_len_q;
    r_dest_d  = r_dest_q;
    r_drop_d  = r_drop_q;
    if (r_state_q == E_IDLE) begin
      // unroutable cid: swallow the whole packet without presenting it
      if (int'(h_cid) >= num_in_p) r_deq = r_hv;
      else begin
        r_vo[h_cid] = r_hv;
        r_deq = r_hv & link.resp_ready_and_i[h_cid];
      end
      if (r_deq && (h_len != '0)) begin
        r_state_d = E_BUSY;
        r_len_d   = h_len;
        r_dest_d  = h_cid;
        r_drop_d  = (int'(h_cid) >= num_in_p);
      end
    end else begin
      if (r_drop_q) r_deq = r_hv;
      else begin
        r_vo[r_dest_q] = r_hv;
        r_deq = r_hv & link.resp_ready_and_i[r_dest_q];
      end
      if (r_deq) begin
        r_len_d = r_len_q - 1'b1;
        if (r_len_q == len_t'(1)) r_state_d = E_IDLE;
      end
    end
    r_mem_d = r_mem_q;
    r_wr_d  = r_wr_q;
    r_rd_d  = r_rd_q;
    if (r_enq) begin
      r_mem_d[r_wr_q] = link.resp_data_i;
      r_wr_d = ~r_wr_q;
    end
    if (r_deq) r_rd_d = ~r_rd_q;
    r_cnt_d = r_cnt_q + {1'b0, r_enq} - {1'b0, r_deq};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      f_mem_q   <= '{default: '0};
      f_wr_q    <= 1'b0;
      f_rd_q    <= 1'b0;
      f_cnt_q   <= '0;
      f_state_q <= E_IDLE;
      f_len_q   <= '0;
      rr_q      <= '0;
      lock_q    <= '0;
      r_mem_q   <= '{default: '0};
      r_wr_q    <= 1'b0;
      r_rd_q    <= 1'b0;
      r_cnt_q   <= '0;
      r_state_q <= E_IDLE;
      r_len_q   <= '0;
      r_dest_q  <= '0;
      r_drop_q  <= 1'b0;
    end else begin
      f_mem_q   <= f_mem_d;
      f_wr_q    <= f_wr_d;
      f_rd_q    <= f_rd_d;
      f_cnt_q   <= f_cnt_d;
      f_state_q <= f_state_d;
      f_len_q   <= f_len_d;
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      r_mem_q   <= r_mem_d;
      r_wr_q    <= r_wr_d;
      r_rd_q    <= r_rd_d;
      r_cnt_q   <= r_cnt_d;
      r_state_q <= r_state_d;
      r_len_q   <= r_len_d;
      r_dest_q  <= r_dest_d;
      r_drop_q  <= r_drop_d;
    end
  end

  assign link.cmd_ready_and_o  = cmd_rdy & {num_in_p{~reset_i}};
  assign link.cmd_v_o          = (f_cnt_q != 2'd0);
  assign link.cmd_data_o       = f_mem_q[f_rd_q];
  assign link.resp_ready_and_o = resp_rdy;
  assign link.resp_v_o         = r_vo;

  for (genvar g = 0; g < num_in_p; g++) begin : g_resp_lane
    assign link.resp_data_o[g] = r_head;
  end
endmodule

// File: tb/tb_bp_mem_link_concentrator.sv
// Bench for bp_mem_link_concentrator: directed scenarios on 4- and 3-channel instances
// plus randomized command traffic checked against a packet-level arbitration model.
`timescale 1ns/1ps
module tb_bp_mem_link_concentrator;
  localparam int NI = 4, NI3 = 3, FW = 64;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0, errors = 0;

  always #5 clk = ~clk;

  bp_mem_link_concentrator_if #(.num_in_p(NI),  .flit_width_p(FW)) if4 ();
  bp_mem_link_concentrator_if #(.num_in_p(NI3), .flit_width_p(FW)) if3 ();

  bp_mem_link_concentrator #(.num_in_p(NI))  dut4 (.clk_i(clk), .reset_i(rst), .link(if4));
  bp_mem_link_concentrator #(.num_in_p(NI3)) dut3 (.clk_i(clk), .reset_i(rst), .link(if3));

  function automatic logic [63:0] rnd();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] mk_hdr(int len, int cid);
    logic [63:0] h;
    h = {$urandom, $urandom};
    h[3:0] = 4'(len);
    h[5:4] = 2'(cid);
    return h;
  endfunction

  function automatic logic [63:0] set_cid(logic [63:0] f, int c);
    f[5:4] = 2'(c);
    return f;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    if4.cmd_v_i = '0; if4.cmd_data_i = '0; if4.cmd_ready_and_i = 1'b0;
    if4.resp_v_i = 1'b0; if4.resp_data_i = '0; if4.resp_ready_and_i = '0;
    if3.cmd_v_i = '0; if3.cmd_data_i = '0; if3.cmd_ready_and_i = 1'b0;
    if3.resp_v_i = 1'b0; if3.resp_data_i = '0; if3.resp_ready_and_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if4.cmd_v_i = '1; if4.cmd_ready_and_i = 1'b1; if4.resp_v_i = 1'b1; if4.resp_ready_and_i = '1;
    if3.cmd_v_i = '1; if3.resp_v_i = 1'b1;
    @(negedge clk);
    vectors++; if (if4.cmd_ready_and_o !== 4'b0) begin errors++; $display("FAIL reset_cmd_rdy: got %b want 0000", if4.cmd_ready_and_o); end
    vectors++; if (if4.cmd_v_o !== 1'b0) begin errors++; $display("FAIL reset_cmd_v: got %b want 0", if4.cmd_v_o); end
    vectors++; if (if4.resp_ready_and_o !== 1'b0) begin errors++; $display("FAIL reset_resp_rdy: got %b want 0", if4.resp_ready_and_o); end
    vectors++; if (if4.resp_v_o !== 4'b0) begin errors++; $display("FAIL reset_resp_v: got %b want 0000", if4.resp_v_o); end
    vectors++; if (if3.cmd_ready_and_o !== 3'b0 || if3.resp_ready_and_o !== 1'b0) begin
      errors++; $display("FAIL reset_dut3_rdy: got %b/%b want 000/0", if3.cmd_ready_and_o, if3.resp_ready_and_o); end
    do_reset();
  endtask

  task automatic test_single_packet();
    logic [63:0] h, a, b;
    do_reset();
    h = mk_hdr(2, 0); a = rnd(); b = rnd();
    if4.cmd_ready_and_i = 1'b1;
    if4.cmd_v_i[1] = 1'b1; if4.cmd_data_i[1] = h;
    @(negedge clk);
    vectors++; if (if4.cmd_ready_and_o !== 4'b0010 || if4.cmd_v_o !== 1'b0) begin
      errors++; $display("FAIL single_grant: got rdy=%b v=%b want 0010/0", if4.cmd_ready_and_o, if4.cmd_v_o); end
    tick(); if4.cmd_data_i[1] = a;
    @(negedge clk);
    vectors++; if (if4.cmd_v_o !== 1'b1 || if4.cmd_data_o !== set_cid(h, 1)) begin
      errors++; $display("FAIL single_hdr: got v=%b %h want 1 %h", if4.cmd_v_o, if4.cmd_data_o, set_cid(h, 1)); end
    tick(); if4.cmd_data_i[1] = b;
    @(negedge clk);
    vectors++; if (if4.cmd_v_o !== 1'b1 || if4.cmd_data_o !== a) begin
      errors++; $display("FAIL single_body_a: got v=%b %h want 1 %h", if4.cmd_v_o, if4.cmd_data_o, a); end
    tick(); if4.cmd_v_i[1] = 1'b0;
    @(negedge clk);
    vectors++; if (if4.cmd_v_o !== 1'b1 || if4.cmd_data_o !== b) begin
      errors++; $display("FAIL single_body_b: got v=%b %h want 1 %h", if4.cmd_v_o, if4.cmd_data_o, b); end
    tick();
    @(negedge clk);
    vectors++; if (if4.cmd_v_o !== 1'b0) begin errors++; $display("FAIL single_drain: got v=%b want 0", if4.cmd_v_o); end
  endtask

  task automatic test_round_robin();
    int order [6] = '{0, 1, 2, 3, 0, 2};
    do_reset();
    if4.cmd_ready_and_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if4.cmd_v_i[2'(c)] = 1'b1; if4.cmd_data_i[2'(c)] = mk_hdr(0, 0);
    end
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin if4.cmd_v_i[0] = 1'b1; if4.cmd_v_i[2] = 1'b1; end
      @(negedge clk);
      vectors++; if (if4.cmd_ready_and_o !== 4'(1 << order[k])) begin
        errors++; $display("FAIL rr_grant%0d: got %b want %b", k, if4.cmd_ready_and_o, 4'(1 << order[k])); end
      tick(); if4.cmd_v_i[2'(order[k])] = 1'b0;
    end
    tick(); tick();
  endtask

  task automatic test_wormhole();
    logic [63:0] pk [4];
    logic [63:0] h1;
    do_reset();
    if4.cmd_ready_and_i = 1'b1;
    pk[0] = mk_hdr(3, 0); pk[1] = rnd(); pk[2] = rnd(); pk[3] = rnd();
    h1 = mk_hdr(0, 0);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin if4.cmd_v_i[0] = 1'b1; if4.cmd_data_i[0] = pk[k]; end
      else if4.cmd_v_i[0] = 1'b0;
      if (k >= 1) begin if4.cmd_v_i[1] = 1'b1; if4.cmd_data_i[1] = h1; end
      @(negedge clk);
      vectors++; if (if4.cmd_ready_and_o !== ((k < 4) ? 4'b0001 : 4'b0010)) begin
        errors++; $display("FAIL worm_rdy%0d: got %b want %b", k, if4.cmd_ready_and_o, (k < 4) ? 4'b0001 : 4'b0010); end
      tick();
    end
    if4.cmd_v_i[1] = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_backpressure();
    logic [63:0] pk [4];
    logic [63:0] got [$];
    int idx, cyc;
    logic acc;
    do_reset();
    pk[0] = mk_hdr(3, 1); pk[1] = rnd(); pk[2] = rnd(); pk[3] = rnd();
    idx = 0; cyc = 0;
    while (got.size() < 4 && cyc < 30) begin
      if4.cmd_v_i[2] = (idx < 4);
      if (idx < 4) if4.cmd_data_i[2] = pk[idx];
      if4.cmd_ready_and_i = (cyc >= 5);
      @(negedge clk);
      if (cyc >= 2 && cyc <= 4) begin
        vectors++; if (if4.cmd_ready_and_o !== 4'b0 || if4.cmd_v_o !== 1'b1) begin
          errors++; $display("FAIL bp_full%0d: got rdy=%b v=%b want 0000/1", cyc, if4.cmd_ready_and_o, if4.cmd_v_o); end
      end
      acc = if4.cmd_v_i[2] && if4.cmd_ready_and_o[2];
      if (if4.cmd_v_o && if4.cmd_ready_and_i) got.push_back(if4.cmd_data_o);
      tick();
      if (acc) idx++;
      cyc++;
    end
    if4.cmd_v_i[2] = 1'b0;
    vectors++; if (got.size() != 4) begin errors++; $display("FAIL bp_count: got %0d flits want 4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      vectors++; if (got[k] !== ((k == 0) ? set_cid(pk[0], 2) : pk[k])) begin
        errors++; $display("FAIL bp_flit%0d: got %h want %h", k, got[k], (k == 0) ? set_cid(pk[0], 2) : pk[k]); end
    end
    @(negedge clk);
    vectors++; if (if4.cmd_v_o !== 1'b0) begin errors++; $display("FAIL bp_dup: got v=%b want 0", if4.cmd_v_o); end
    tick();
  endtask

  task automatic test_resp_steer();
    logic [63:0] h, b;
    do_reset();
    h = mk_hdr(1, 2); b = rnd();
    if4.resp_ready_and_i = '1;
    if4.resp_v_i = 1'b1; if4.resp_data_i = h;
    @(negedge clk);
    vectors++; if (if4.resp_ready_and_o !== 1'b1 || if4.resp_v_o !== 4'b0) begin
      errors++; $display("FAIL steer_idle: got rdy=%b v=%b want 1/0000", if4.resp_ready_and_o, if4.resp_v_o); end
    tick(); if4.resp_data_i = b;
    @(negedge clk);
    vectors++; if (if4.resp_v_o !== 4'b0100 || if4.resp_data_o[2] !== h || if4.resp_data_o[0] !== h) begin
      errors++; $display("FAIL steer_hdr: got v=%b %h want 0100 %h", if4.resp_v_o, if4.resp_data_o[2], h); end
    tick(); if4.resp_v_i = 1'b0;
    @(negedge clk);
    vectors++; if (if4.resp_v_o !== 4'b0100 || if4.resp_data_o[2] !== b) begin
      errors++; $display("FAIL steer_body: got v=%b %h want 0100 %h", if4.resp_v_o, if4.resp_data_o[2], b); end
    tick();
    @(negedge clk);
    vectors++; if (if4.resp_v_o !== 4'b0) begin errors++; $display("FAIL steer_drain: got v=%b want 0000", if4.resp_v_o); end
  endtask

  task automatic test_resp_discard();
    logic [63:0] pk [3];
    int idx, bad, good;
    logic acc;
    do_reset();
    pk[0] = mk_hdr(1, 3); pk[1] = rnd(); pk[2] = mk_hdr(0, 1);
    idx = 0; bad = 0; good = 0;
    if3.resp_ready_and_i = '1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if3.resp_v_i = (idx < 3);
      if (idx < 3) if3.resp_data_i = pk[idx];
      @(negedge clk);
      if (if3.resp_v_o != 3'b0) begin
        if (if3.resp_v_o == 3'b010 && if3.resp_data_o[1] == pk[2]) good++;
        else bad++;
      end
      acc = if3.resp_v_i && if3.resp_ready_and_o;
      tick();
      if (acc) idx++;
    end
    if3.resp_v_i = 1'b0;
    vectors++; if (idx != 3) begin errors++; $display("FAIL discard_accept: got %0d flits taken want 3", idx); end
    vectors++; if (bad != 0) begin errors++; $display("FAIL discard_leak: got %0d stray valid cycles want 0", bad); end
    vectors++; if (good != 1) begin errors++; $display("FAIL discard_next: got %0d deliveries of cid1 pkt want 1", good); end
  endtask

  task automatic test_async_reset();
    logic [63:0] h3;
    do_reset();
    if4.cmd_ready_and_i = 1'b1;
    if4.cmd_v_i[0] = 1'b1; if4.cmd_data_i[0] = mk_hdr(3, 0);
    tick(); if4.cmd_data_i[0] = rnd();
    tick(); if4.cmd_data_i[0] = rnd();
    @(negedge clk);
    vectors++; if (if4.cmd_v_o !== 1'b1) begin errors++; $display("FAIL areset_pre: got v=%b want 1", if4.cmd_v_o); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (if4.cmd_v_o !== 1'b0 || if4.cmd_ready_and_o !== 4'b0 || if4.resp_ready_and_o !== 1'b0) begin
      errors++; $display("FAIL areset_now: got v=%b rdy=%b rrdy=%b want 0/0000/0", if4.cmd_v_o, if4.cmd_ready_and_o, if4.resp_ready_and_o); end
    if4.cmd_v_i[0] = 1'b0;
    h3 = mk_hdr(0, 0);
    if4.cmd_v_i[3] = 1'b1; if4.cmd_data_i[3] = h3;
    @(negedge clk); rst = 1'b0; #1;
    vectors++; if (if4.cmd_ready_and_o !== 4'b1000) begin
      errors++; $display("FAIL areset_grant: got %b want 1000", if4.cmd_ready_and_o); end
    tick(); if4.cmd_v_i[3] = 1'b0;
    @(negedge clk);
    vectors++; if (if4.cmd_v_o !== 1'b1 || if4.cmd_data_o !== set_cid(h3, 3)) begin
      errors++; $display("FAIL areset_out: got v=%b %h want 1 %h", if4.cmd_v_o, if4.cmd_data_o, set_cid(h3, 3)); end
    tick();
  endtask

  // Packet-level model: arbitration picks the first valid channel at or after the
  // channel following the last completed packet; a packet's flits go out contiguously.
  task automatic test_random_traffic();
    logic [63:0] src [4][$];
    logic [63:0] exp_q [$];
    logic [63:0] f;
    logic [3:0]  vv, acc, exp_rdy;
    int m_rr, m_lock, m_cnt, tgt, cyc, len, ch, occ;
    bit m_busy, space;
    m_rr = 0; m_lock = 0; m_cnt = 0; m_busy = 1'b0; cyc = 0;
    do_reset();
    for (int c = 0; c < 4; c++)
      for (int p = 0; p < 6; p++) begin
        len = $urandom_range(0, 3);
        src[c].push_back(mk_hdr(len, $urandom_range(0, 3)));
        for (int b = 0; b < len; b++) src[c].push_back(rnd());
      end
    while ((src[0].size() + src[1].size() + src[2].size() + src[3].size() + exp_q.size()) != 0 && cyc < 2000) begin
      for (int c = 0; c < 4; c++)
        if (!if4.cmd_v_i[2'(c)] && src[c].size() != 0 && $urandom_range(0, 3) != 0) begin
          if4.cmd_v_i[2'(c)] = 1'b1; if4.cmd_data_i[2'(c)] = src[c][0];
        end
      if4.cmd_ready_and_i = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      vv    = if4.cmd_v_i;
      occ   = exp_q.size();
      space = (occ < 2) || if4.cmd_ready_and_i;
      tgt   = -1;
      if (m_busy) tgt = m_lock;
      else for (int i = 3; i >= 0; i--) if (vv[2'((m_rr + i) % 4)]) tgt = (m_rr + i) % 4;
      exp_rdy = (tgt >= 0 && space) ? 4'(1 << tgt) : 4'b0;
      vectors++; if (if4.cmd_ready_and_o !== exp_rdy) begin
        errors++; $display("FAIL rand_rdy cyc%0d: got %b want %b", cyc, if4.cmd_ready_and_o, exp_rdy); end
      vectors++; if (if4.cmd_v_o !== (occ != 0)) begin
        errors++; $display("FAIL rand_v cyc%0d: got %b want %b", cyc, if4.cmd_v_o, occ != 0); end
      if (occ != 0) begin
        vectors++; if (if4.cmd_data_o !== exp_q[0]) begin
          errors++; $display("FAIL rand_data cyc%0d: got %h want %h", cyc, if4.cmd_data_o, exp_q[0]); end
        if (if4.cmd_ready_and_i) void'(exp_q.pop_front());
      end
      acc = vv & if4.cmd_ready_and_o;
      if (acc != 4'b0) begin
        ch = 0;
        for (int c = 3; c >= 0; c--) if (acc[2'(c)]) ch = c;
        f = src[ch][0];
        if (m_busy) begin
          m_cnt--;
          if (m_cnt == 0) begin m_busy = 1'b0; m_rr = (ch + 1) % 4; end
        end else begin
          f[5:4] = 2'(ch);
          len = int'(f[3:0]);
          if (len == 0) m_rr = (ch + 1) % 4;
          else begin m_busy = 1'b1; m_lock = ch; m_cnt = len; end
        end
        exp_q.push_back(f);
      end
      tick();
      for (int c = 0; c < 4; c++)
        if (acc[2'(c)]) begin void'(src[c].pop_front()); if4.cmd_v_i[2'(c)] = 1'b0; end
      cyc++;
    end
    vectors++; if (cyc >= 2000) begin errors++; $display("FAIL rand_timeout: %0d flits outstanding after %0d cycles", exp_q.size(), cyc); end
    idle_inputs();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    #1;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_wormhole();
    test_backpressure();
    test_resp_steer();
    test_resp_discard();
    test_async_reset();
    test_random_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
